// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: slot layout, the "operand unused"
// use-time code and the register-file forward select.
package hazard_pkg;

   localparam int HZ_AW_MAX = 8;
   localparam int HZ_TW_MAX = 4;
   localparam int T_UNUSED  = 3;
   localparam int SEL_GRF   = 0;

   localparam logic [HZ_TW_MAX-1:0] T_ONE = 1;

   // Slot fields are sized for the widest supported configuration; narrower
   // register numbers and timers are zero-extended into them.
   typedef struct packed {
      logic                 valid;
      logic [HZ_AW_MAX-1:0] A3;
      logic [HZ_TW_MAX-1:0] Tnew;
   } hz_entry_t;

   function automatic logic [HZ_TW_MAX-1:0] satDec(input logic [HZ_TW_MAX-1:0] t);
      return (t == '0) ? '0 : t - T_ONE;
   endfunction

endpackage

// File: rtl/hazard_entry.sv
// One scoreboard slot: captures the entry from the stage above with its time-to-ready
// decremented, or becomes a bubble.
module hazard_entry
   import hazard_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bubble_i,
   input  logic                 valid_i,
   input  logic [HZ_AW_MAX-1:0] a3_i,
   input  logic [HZ_TW_MAX-1:0] tnew_i,
   output logic                 valid_o,
   output logic [HZ_AW_MAX-1:0] a3_o,
   output logic [HZ_TW_MAX-1:0] tnew_o
);

   hz_entry_t entryQ, entryD;

   always_comb begin
      entryD = '0;
      if (!bubble_i) begin
         entryD.valid = valid_i;
         entryD.A3    = a3_i;
         entryD.Tnew  = satDec(tnew_i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entryQ <= '0;
      end else begin
         entryQ <= entryD;
      end
   end

   assign valid_o = entryQ.valid;
   assign a3_o    = entryQ.A3;
   assign tnew_o  = entryQ.Tnew;

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth-generic hazard/forwarding controller for the D stage of the MIPS pipeline.
// Define HAZARD_MDU_STALL_EN to build the multiply/divide busy interlock.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NSTAGE  = 3,
   parameter int REG_AW  = 5,
   parameter int TW      = 2,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [REG_AW-1:0]             D_rs,
   input  logic [REG_AW-1:0]             D_rt,
   input  logic [TW-1:0]                 D_T_rs_use,
   input  logic [TW-1:0]                 D_T_rt_use,
   input  logic [REG_AW-1:0]             D_A3,
   input  logic                          D_RegWrite,
   input  logic [TW-1:0]                 D_T_new,
   input  logic                          D_start,
   input  logic                          D_is_div,
   input  logic                          D_md_use,
   input  logic                          flush,
   output logic                          stall,
   output logic [$clog2(NSTAGE+1)-1:0]   fwd_sel_rs,
   output logic [$clog2(NSTAGE+1)-1:0]   fwd_sel_rt,
   output logic                          busy
);

   localparam int SW = $clog2(NSTAGE+1);
   localparam logic [TW-1:0] TU = TW'(T_UNUSED);

   logic                 stValid [1:NSTAGE];
   logic [HZ_AW_MAX-1:0] stA3    [1:NSTAGE];
   logic [HZ_TW_MAX-1:0] stTnew  [1:NSTAGE];

   logic [HZ_AW_MAX-1:0] rsExt, rtExt;
   logic                 hitRs, hitRt;
   logic [SW-1:0]        selRs, selRt;
   logic [HZ_TW_MAX-1:0] tnewRs, tnewRt;
   logic                 stallRs, stallRt, mduStall;

   // Stage 1 is fed from D; the last stage keeps advancing through a flush so W retires.
   for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
      if (k == 1) begin : g_head
         hazard_entry u_entry (
            .clk      (clk),
            .reset    (reset),
            .bubble_i (stall | flush),
            .valid_i  (D_RegWrite && (D_A3 != '0)),
            .a3_i     (HZ_AW_MAX'(D_A3)),
            .tnew_i   (HZ_TW_MAX'(D_T_new)),
            .valid_o  (stValid[k]),
            .a3_o     (stA3[k]),
            .tnew_o   (stTnew[k])
         );
      end else begin : g_tail
         hazard_entry u_entry (
            .clk      (clk),
            .reset    (reset),
            .bubble_i ((k < NSTAGE) ? flush : 1'b0),
            .valid_i  (stValid[k-1]),
            .a3_i     (stA3[k-1]),
            .tnew_i   (stTnew[k-1]),
            .valid_o  (stValid[k]),
            .a3_o     (stA3[k]),
            .tnew_o   (stTnew[k])
         );
      end
   end

   assign rsExt = HZ_AW_MAX'(D_rs);
   assign rtExt = HZ_AW_MAX'(D_rt);

   // Scanning oldest-to-youngest lets the youngest match overwrite older ones.
   always_comb begin
      hitRs  = 1'b0;
      hitRt  = 1'b0;
      selRs  = '0;
      selRt  = '0;
      tnewRs = '0;
      tnewRt = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (stValid[k] && (stA3[k] == rsExt) && (rsExt != '0)) begin
            hitRs  = 1'b1;
            selRs  = SW'(k);
            tnewRs = stTnew[k];
         end
         if (stValid[k] && (stA3[k] == rtExt) && (rtExt != '0)) begin
            hitRt  = 1'b1;
            selRt  = SW'(k);
            tnewRt = stTnew[k];
         end
      end
   end

   assign stallRs = hitRs && (D_T_rs_use != TU) && (tnewRs > HZ_TW_MAX'(D_T_rs_use));
   assign stallRt = hitRt && (D_T_rt_use != TU) && (tnewRt > HZ_TW_MAX'(D_T_rt_use));
   assign stall   = stallRs | stallRt | mduStall;

   assign fwd_sel_rs = (hitRs && (tnewRs == '0)) ? selRs : SW'(SEL_GRF);
   assign fwd_sel_rt = (hitRt && (tnewRt == '0)) ? selRt : SW'(SEL_GRF);

`ifdef HAZARD_MDU_STALL_EN
   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] CNT_ONE = 1;

   logic [CW-1:0] mduCntQ, mduCntD;
   logic          startQ, startD;
   logic          mduLoad;

   assign mduLoad = D_start && !stall && !flush;

   // A flush leaves the counter alone: the MDU operation already issued still runs to completion.
   always_comb begin
      startD  = mduLoad;
      mduCntD = (mduCntQ != '0) ? mduCntQ - CNT_ONE : '0;
      if (mduLoad) begin
         mduCntD = D_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mduCntQ <= '0;
         startQ  <= 1'b0;
      end else begin
         mduCntQ <= mduCntD;
         startQ  <= startD;
      end
   end

   assign busy     = (mduCntQ != '0) | startQ;
   assign mduStall = D_md_use && busy;
`else
   logic unusedMdu;

   assign unusedMdu = ^{D_start, D_is_div, D_md_use};
   assign busy      = 1'b0;
   assign mduStall  = 1'b0;
`endif

endmodule
